btn_conditioner: RTL
====================

Name: btn_conditioner

Overview:
Input-side front end for the boom_pro game. It receives the raw, bouncing mechanical inputs (start, btn6, sw_input) and turns them into clean, clock-synchronous events for the game FSM. These events are press, release and long-press pulses, plus a debounced switch vector. It sits between the board pins and the game core; clk is 1 MHz.

Parameters:
DEB_CYCLES, 500, consecutive stable cycles required to accept a level change (rejects bounce of up to 499 cycles)
LONG_CYCLES, 4000, cycles a debounced press must be held before start_long fires (counted from the start_press cycle)
SW_W, 7, width of the switch vector

Ports:
clk  in  1  system clock, 1 MHz
sw7  in  1  reset, asynchronous, active-low (0 = reset, 1 = run)
start  in  1  raw start button, active-high, bouncing
btn6  in  1  raw btn6, active-high, bouncing
sw_input  in  SW_W  raw slide switches
start_press  out  1  1-cycle pulse on accepted start press
start_long  out  1  1-cycle pulse when start has been held LONG_CYCLES
start_release  out  1  1-cycle pulse on accepted start release
start_level  out  1  debounced start level
btn6_press  out  1  1-cycle pulse on accepted btn6 press
sw_stable  out  SW_W  debounced switch vector
sw_change  out  1  1-cycle pulse in the cycle sw_stable updates

Behaviour:
- Reset (sw7=0, asynchronous): all outputs 0, all synchronizer flops 0, all counters 0, all FSMs in IDLE. Deasserting sw7 mid-press restarts cleanly. A button already held at release of reset must first be seen at 0 before it can produce a press; reset cannot produce a press.
- Synchronization: every raw input passes through a 2-flop synchronizer. "s_x" denotes the synchronized value, 2 cycles after the raw input.
- Start FSM states: IDLE, ARM, PRESS_WAIT, HELD, LONG, REL_WAIT.
  - IDLE: s_start=0 for 1 cycle -> ARM. Reset lands here so that a held button is ignored.
  - ARM: s_start=1 -> PRESS_WAIT, deb_cnt=1.
  - PRESS_WAIT: s_start=1 -> deb_cnt++. When deb_cnt==DEB_CYCLES: go to HELD, pulse start_press, set start_level=1, clear hold_cnt. s_start=0 -> back to ARM, deb_cnt=0 (bounce rejected, no output).
  - HELD: hold_cnt++ each cycle. When hold_cnt==LONG_CYCLES-1: pulse start_long, go to LONG. s_start=0 -> REL_WAIT, deb_cnt=1.
  - LONG: waits for s_start=0 -> REL_WAIT, deb_cnt=1. No repeat of start_long.
  - REL_WAIT: s_start=0 -> deb_cnt++. When deb_cnt==DEB_CYCLES: pulse start_release, set start_level=0, go to ARM. s_start=1 -> return to HELD, or to LONG if start_long already fired; hold_cnt is kept, not cleared.
- Latency: a clean raw edge at cycle t gives start_press at cycle t+DEB_CYCLES+2. start_long fires exactly LONG_CYCLES cycles after start_press, provided there is no accepted release in between.
- start_press and start_long can never occur in the same cycle.
- btn6: same debounce path (IDLE/ARM/PRESS_WAIT/HELD/REL_WAIT). It has no long-press detection and outputs only btn6_press.
- Switches:
  - One shared counter watches the whole s_sw vector.
  - Any change in s_sw versus its previous cycle clears the counter.
  - When the counter reaches DEB_CYCLES with s_sw != sw_stable: sw_stable <= s_sw and sw_change pulses in the same cycle.
  - After reset sw_stable=0. A nonzero switch state present at reset produces one sw_change DEB_CYCLES+2 cycles after release of reset.
- Counter width: clog2(max(DEB_CYCLES, LONG_CYCLES)+1). Counters saturate and never wrap.
- Simultaneous events on start, btn6 and the switches are independent. All outputs may pulse in the same cycle.

Test Plan:
1. Reset: sw7=0 with start=1 and sw_input=7'h55 -> all outputs 0. Raise sw7 while start is still held -> no start_press. sw_stable=7'h55 and sw_change pulse at cycle 502 after the sw7 rise.
2. Bounce rejection: start high 300 cycles, low 300, high 150, low -> no start_press, no start_release, start_level stays 0.
3. Clean press: start high 1000 cycles then low -> start_press at cycle 502 after the rise, start_release at cycle 502 after the fall, no start_long.
4. Long press: start held 6000 cycles -> start_press at cycle 502, start_long at cycle 4502, a single pulse each.
5. Release bounce: held 1000 cycles, then a 200-cycle low glitch, then held again -> no start_release during the glitch. hold_cnt continues, and start_long fires if the total hold reaches 4000 cycles after start_press.
6. Concurrency: btn6 pressed and sw_input changed to 7'h01 in the same cycle as start -> btn6_press, start_press and sw_change all pulse at cycle 502. Drop sw7 at cycle 300 of a press -> outputs clear immediately and no pulse follows.

Source files
------------

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizes and debounces the boom_pro front-panel inputs into
// press / release / long-press pulses and a debounced slide-switch vector.
module btn_conditioner #(
   parameter int DEB_CYCLES  = 500,
   parameter int LONG_CYCLES = 4000,
   parameter int SW_W        = 7
) (
   input  logic            clk,
   input  logic            sw7,
   input  logic            start,
   input  logic            btn6,
   input  logic [SW_W-1:0] sw_input,
   output logic            start_press,
   output logic            start_long,
   output logic            start_release,
   output logic            start_level,
   output logic            btn6_press,
   output logic [SW_W-1:0] sw_stable,
   output logic            sw_change
);

   localparam int MAX_CYC = (DEB_CYCLES > LONG_CYCLES) ? DEB_CYCLES : LONG_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 32'sd1);
   localparam int SYN_W   = SW_W + 2;

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEB_CYCLES);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 32'sd1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 32'sd1);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ARM        = 3'd1,
      PRESS_WAIT = 3'd2,
      HELD       = 3'd3,
      LONG       = 3'd4,
      REL_WAIT   = 3'd5
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic [CNT_W-1:0] lim);
      if (v >= lim) begin
         sat_inc = lim;
      end else begin
         sat_inc = v + CNT_ONE;
      end
   endfunction

   logic [SYN_W-1:0] sync1_r;
   logic [SYN_W-1:0] sync2_r;
   logic [1:0]       vld_r;
   logic             s_start_s;
   logic             s_btn6_s;
   logic             sync_ok_s;
   logic [SW_W-1:0]  s_sw_s;
   logic [SW_W-1:0]  sw_next_s;

   // Two-flop synchronizer for every raw input, plus a marker for when it holds real samples.
   always_ff @(posedge clk or negedge sw7) begin
      if (!sw7) begin
         sync1_r <= {SYN_W{1'b0}};
         sync2_r <= {SYN_W{1'b0}};
         vld_r   <= 2'b00;
      end else begin
         sync1_r <= {sw_input, btn6, start};
         sync2_r <= sync1_r;
         vld_r   <= {vld_r[0], 1'b1};
      end
   end

   assign s_start_s = sync2_r[0];
   assign s_btn6_s  = sync2_r[1];
   assign s_sw_s    = sync2_r[SYN_W-1:2];
   assign sw_next_s = sync1_r[SYN_W-1:2];
   // The reset-flushed zeros are not a genuine release; IDLE waits until the pipe is full.
   assign sync_ok_s = vld_r[1];

   // ------------------------------------------------------------------ start
   state_t           st_r;
   state_t           st_n_s;
   logic [CNT_W-1:0] deb_cnt_r;
   logic [CNT_W-1:0] deb_cnt_n_s;
   logic [CNT_W-1:0] hold_cnt_r;
   logic [CNT_W-1:0] hold_cnt_n_s;
   logic             long_fired_r;
   logic             long_fired_n_s;
   logic             press_r;
   logic             press_n_s;
   logic             long_r;
   logic             long_n_s;
   logic             rel_r;
   logic             rel_n_s;
   logic             level_r;
   logic             level_n_s;
   logic             long_due_s;

   assign long_due_s = !long_fired_r && (hold_cnt_r == LONG_LAST);

   // Start FSM next-state: debounce both edges, hold counter keeps running through release bounce.
   always_comb begin
      st_n_s         = st_r;
      deb_cnt_n_s    = deb_cnt_r;
      hold_cnt_n_s   = hold_cnt_r;
      long_fired_n_s = long_fired_r;
      level_n_s      = level_r;
      press_n_s      = 1'b0;
      long_n_s       = 1'b0;
      rel_n_s        = 1'b0;
      case (st_r)
         IDLE: begin
            if (sync_ok_s && !s_start_s) begin
               st_n_s = ARM;
            end else begin
               st_n_s = IDLE;
            end
         end
         ARM: begin
            if (s_start_s) begin
               st_n_s      = PRESS_WAIT;
               deb_cnt_n_s = CNT_ONE;
            end else begin
               st_n_s      = ARM;
               deb_cnt_n_s = CNT_ZERO;
            end
         end
         PRESS_WAIT: begin
            if (!s_start_s) begin
               st_n_s      = ARM;
               deb_cnt_n_s = CNT_ZERO;
            end else if (deb_cnt_r >= DEB_LAST) begin
               st_n_s         = HELD;
               deb_cnt_n_s    = DEB_MAX;
               hold_cnt_n_s   = CNT_ZERO;
               long_fired_n_s = 1'b0;
               press_n_s      = 1'b1;
               level_n_s      = 1'b1;
            end else begin
               deb_cnt_n_s = sat_inc(deb_cnt_r, DEB_MAX);
            end
         end
         HELD: begin
            if (long_due_s) begin
               long_n_s       = 1'b1;
               long_fired_n_s = 1'b1;
            end else begin
               hold_cnt_n_s = sat_inc(hold_cnt_r, LONG_LAST);
            end
            if (!s_start_s) begin
               st_n_s      = REL_WAIT;
               deb_cnt_n_s = CNT_ONE;
            end else if (long_due_s) begin
               st_n_s = LONG;
            end else begin
               st_n_s = HELD;
            end
         end
         LONG: begin
            if (!s_start_s) begin
               st_n_s      = REL_WAIT;
               deb_cnt_n_s = CNT_ONE;
            end else begin
               st_n_s = LONG;
            end
         end
         REL_WAIT: begin
            if (!s_start_s && (deb_cnt_r >= DEB_LAST)) begin
               st_n_s      = ARM;
               deb_cnt_n_s = CNT_ZERO;
               rel_n_s     = 1'b1;
               level_n_s   = 1'b0;
            end else begin
               if (long_due_s) begin
                  long_n_s       = 1'b1;
                  long_fired_n_s = 1'b1;
               end else if (!long_fired_r) begin
                  hold_cnt_n_s = sat_inc(hold_cnt_r, LONG_LAST);
               end else begin
                  hold_cnt_n_s = hold_cnt_r;
               end
               if (!s_start_s) begin
                  st_n_s      = REL_WAIT;
                  deb_cnt_n_s = sat_inc(deb_cnt_r, DEB_MAX);
               end else if (long_fired_r || long_due_s) begin
                  st_n_s      = LONG;
                  deb_cnt_n_s = CNT_ZERO;
               end else begin
                  st_n_s      = HELD;
                  deb_cnt_n_s = CNT_ZERO;
               end
            end
         end
         default: begin
            st_n_s         = IDLE;
            deb_cnt_n_s    = CNT_ZERO;
            hold_cnt_n_s   = CNT_ZERO;
            long_fired_n_s = 1'b0;
            level_n_s      = 1'b0;
         end
      endcase
   end

   // Start FSM state, counters and registered event outputs.
   always_ff @(posedge clk or negedge sw7) begin
      if (!sw7) begin
         st_r         <= IDLE;
         deb_cnt_r    <= CNT_ZERO;
         hold_cnt_r   <= CNT_ZERO;
         long_fired_r <= 1'b0;
         press_r      <= 1'b0;
         long_r       <= 1'b0;
         rel_r        <= 1'b0;
         level_r      <= 1'b0;
      end else begin
         st_r         <= st_n_s;
         deb_cnt_r    <= deb_cnt_n_s;
         hold_cnt_r   <= hold_cnt_n_s;
         long_fired_r <= long_fired_n_s;
         press_r      <= press_n_s;
         long_r       <= long_n_s;
         rel_r        <= rel_n_s;
         level_r      <= level_n_s;
      end
   end

   // ------------------------------------------------------------------- btn6
   state_t           b_st_r;
   state_t           b_st_n_s;
   logic [CNT_W-1:0] b_deb_r;
   logic [CNT_W-1:0] b_deb_n_s;
   logic             b_press_r;
   logic             b_press_n_s;

   // btn6 FSM next-state: same edge debounce as start, without long-press tracking.
   always_comb begin
      b_st_n_s    = b_st_r;
      b_deb_n_s   = b_deb_r;
      b_press_n_s = 1'b0;
      case (b_st_r)
         IDLE: begin
            if (sync_ok_s && !s_btn6_s) begin
               b_st_n_s = ARM;
            end else begin
               b_st_n_s = IDLE;
            end
         end
         ARM: begin
            if (s_btn6_s) begin
               b_st_n_s  = PRESS_WAIT;
               b_deb_n_s = CNT_ONE;
            end else begin
               b_st_n_s  = ARM;
               b_deb_n_s = CNT_ZERO;
            end
         end
         PRESS_WAIT: begin
            if (!s_btn6_s) begin
               b_st_n_s  = ARM;
               b_deb_n_s = CNT_ZERO;
            end else if (b_deb_r >= DEB_LAST) begin
               b_st_n_s    = HELD;
               b_deb_n_s   = DEB_MAX;
               b_press_n_s = 1'b1;
            end else begin
               b_deb_n_s = sat_inc(b_deb_r, DEB_MAX);
            end
         end
         HELD: begin
            if (!s_btn6_s) begin
               b_st_n_s  = REL_WAIT;
               b_deb_n_s = CNT_ONE;
            end else begin
               b_st_n_s = HELD;
            end
         end
         REL_WAIT: begin
            if (s_btn6_s) begin
               b_st_n_s  = HELD;
               b_deb_n_s = CNT_ZERO;
            end else if (b_deb_r >= DEB_LAST) begin
               b_st_n_s  = ARM;
               b_deb_n_s = CNT_ZERO;
            end else begin
               b_deb_n_s = sat_inc(b_deb_r, DEB_MAX);
            end
         end
         default: begin
            b_st_n_s  = IDLE;
            b_deb_n_s = CNT_ZERO;
         end
      endcase
   end

   // btn6 FSM state and registered press pulse.
   always_ff @(posedge clk or negedge sw7) begin
      if (!sw7) begin
         b_st_r    <= IDLE;
         b_deb_r   <= CNT_ZERO;
         b_press_r <= 1'b0;
      end else begin
         b_st_r    <= b_st_n_s;
         b_deb_r   <= b_deb_n_s;
         b_press_r <= b_press_n_s;
      end
   end

   // --------------------------------------------------------------- switches
   logic [CNT_W-1:0] sw_cnt_r;
   logic [CNT_W-1:0] sw_cnt_n_s;
   logic [SW_W-1:0]  sw_stable_r;
   logic [SW_W-1:0]  sw_stable_n_s;
   logic             sw_change_r;
   logic             sw_change_n_s;

   // Shared stability counter: any movement of the vector restarts it; update on the last stable cycle.
   always_comb begin
      sw_cnt_n_s    = sw_cnt_r;
      sw_stable_n_s = sw_stable_r;
      sw_change_n_s = 1'b0;
      if (sw_next_s != s_sw_s) begin
         sw_cnt_n_s = CNT_ZERO;
      end else if (sw_cnt_r == DEB_LAST) begin
         sw_cnt_n_s = DEB_MAX;
         if (s_sw_s != sw_stable_r) begin
            sw_stable_n_s = s_sw_s;
            sw_change_n_s = 1'b1;
         end else begin
            sw_stable_n_s = sw_stable_r;
         end
      end else begin
         sw_cnt_n_s = sat_inc(sw_cnt_r, DEB_MAX);
      end
   end

   // Switch debouncer registers.
   always_ff @(posedge clk or negedge sw7) begin
      if (!sw7) begin
         sw_cnt_r    <= CNT_ZERO;
         sw_stable_r <= {SW_W{1'b0}};
         sw_change_r <= 1'b0;
      end else begin
         sw_cnt_r    <= sw_cnt_n_s;
         sw_stable_r <= sw_stable_n_s;
         sw_change_r <= sw_change_n_s;
      end
   end

   assign start_press   = press_r;
   assign start_long    = long_r;
   assign start_release = rel_r;
   assign start_level   = level_r;
   assign btn6_press    = b_press_r;
   assign sw_stable     = sw_stable_r;
   assign sw_change     = sw_change_r;

endmodule
